// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] R15_OFFSET = 32'd8;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} pairs; head is zero when the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, prefetch FIFO and redirect handling.
// Optional FETCH_PERF_EN adds fetch_count / flush_count performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        stall,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rd,
  output logic [31:0] PCPlus8
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   discard_addr;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;
  logic          push;
  logic          pop;
  logic          dropped;
  logic          unused_target_bits;

  assign unused_target_bits = ^BranchTarget[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc;
    push       = 1'b0;
    dropped    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = ~rst & (count < FULL);
        push     = imem_req & imem_ack & ~PCSrc;
        dropped  = imem_req & imem_ack & PCSrc;
        if (PCSrc && imem_req && !imem_ack) state_next = DISCARD;
      end
      DISCARD: begin
        // The old request must complete before the new address can be issued.
        imem_req  = ~rst;
        imem_addr = discard_addr;
        dropped   = imem_req & imem_ack;
        if (imem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      discard_addr <= RESET_PC;
    end else begin
      if (state == FETCH) discard_addr <= fetch_pc;
      if (PCSrc)     fetch_pc <= {BranchTarget[31:2], 2'b00};
      else if (push) fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  assign InstrValid     = (count != '0);
  assign pop            = InstrValid & ~stall & ~PCSrc;
  assign wr_entry.instr = imem_rdata;
  assign wr_entry.pc    = fetch_pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (PCSrc),
    .wr_entry (wr_entry),
    .count    (count),
    .head     (head)
  );

  assign Instr   = head.instr;
  assign Cond    = Instr[31:28];
  assign Op      = Instr[27:26];
  assign Funct   = Instr[25:20];
  assign Rd      = Instr[15:12];
  assign PCPlus8 = head.pc + R15_OFFSET;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push)             fetch_count <= fetch_count + 1'b1;
      if (PCSrc || dropped) flush_count <= flush_count + 1'b1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
